// File: rtl/gap_rd_arb.sv
// gap_rd_arb: round-robin read arbiter and burst sequencer that shares one
// one-cycle-latency memory read port between several fetch engines. A winner
// is picked only in IDLE; its base address and length are latched, the burst
// addresses are issued one per cycle, and the returned words are steered to
// the owner one cycle later with a one-hot valid and a last-beat flag.
module gap_rd_arb #(
    parameter int NREQ = 3,
    parameter int AW   = 16,
    parameter int DW   = 64,
    parameter int LW   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*LW-1:0]      req_len,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    ren,
    output logic [AW-1:0]           raddr,
    input  logic [DW-1:0]           dout,
    output logic [NREQ-1:0]         rvalid,
    output logic [DW-1:0]           rdata,
    output logic                    rlast
);

    localparam int OW = $clog2(NREQ);

    // state | meaning
    // IDLE  | no burst in flight; requests are sampled on the next edge
    // BURST | issuing one read per cycle for the latched owner
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [OW:0]   NREQ_W   = (OW+1)'(NREQ);
    localparam logic [OW-1:0] LAST_IDX = OW'(NREQ - 1);

    logic [0:0]    state_q,  state_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [OW-1:0] owner_q,  owner_d;
    logic [LW-1:0] len_q,    len_d;
    logic [LW-1:0] beat_q,   beat_d;
    logic [AW-1:0] raddr_q,  raddr_d;
    logic [NREQ-1:0] gnt_q,    gnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic            rlast_q,  rlast_d;

    logic [OW-1:0] win;
    logic [OW:0]   cand;
    logic          found;
    logic [AW-1:0] sel_addr;
    logic [LW-1:0] sel_len;
    logic          in_burst;
    logic          last_beat;

    assign in_burst  = (state_q == ST_BURST);
    assign last_beat = in_burst && (beat_q == len_q);

    // Round-robin search: first requester at or after rr_ptr, wrapping
    always_comb begin
        win      = '0;
        cand     = '0;
        found    = 1'b0;
        sel_addr = '0;
        sel_len  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (OW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && req[cand[OW-1:0]]) begin
                found = 1'b1;
                win   = cand[OW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == OW'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_len  = req_len[i*LW +: LW];
            end
        end
    end

    // Next-state logic for the grant/burst sequencer
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        len_d    = len_q;
        beat_d   = beat_q;
        raddr_d  = raddr_q;
        gnt_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_BURST;
                    owner_d    = win;
                    rr_ptr_d   = (win == LAST_IDX) ? '0 : win + 1'b1;
                    len_d      = sel_len;
                    beat_d     = '0;
                    raddr_d    = sel_addr;
                    gnt_d[win] = 1'b1;
                end
            end
            ST_BURST: begin
                if (beat_q == len_q) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    raddr_d = raddr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Return path: the read issued this cycle comes back next cycle
    always_comb begin
        rvalid_d = '0;
        if (in_burst) begin
            rvalid_d[owner_q] = 1'b1;
        end
        rlast_d = last_beat;
    end

    // State and output registers; reset drops any in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            raddr_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            raddr_q  <= raddr_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = in_burst;
    assign ren    = in_burst;
    assign owner  = owner_q;
    assign raddr  = raddr_q;
    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign rdata  = (|rvalid_q) ? dout : '0;

endmodule

// File: tb/tb_gap_rd_arb.sv
// Bench for gap_rd_arb: requester agents post bursts, a transaction-level
// model schedules the expected per-cycle port activity from each grant.
module tb_gap_rd_arb;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 64;
    localparam int LW   = 8;
    localparam int MAXC = 8192;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic [1:0]      owner;
    logic            ren;
    logic [AW-1:0]   raddr;
    logic [DW-1:0]   dout;
    logic [NREQ-1:0] rvalid;
    logic [DW-1:0]   rdata;
    logic            rlast;

    gap_rd_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt), .busy(busy), .owner(owner), .ren(ren), .raddr(raddr),
        .dout(dout), .rvalid(rvalid), .rdata(rdata), .rlast(rlast)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memf(input logic [15:0] a);
        return {a, ~a, a ^ 16'hA5C3, 16'h1234 + a};
    endfunction

    // memory with one-cycle read latency; garbage when not read
    always @(posedge clk) dout <= ren ? memf(raddr) : {$urandom, $urandom};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // expected activity per cycle
    logic [2:0]  e_gnt [MAXC];
    bit          e_busy[MAXC];
    logic [15:0] e_addr[MAXC];
    logic [2:0]  e_rv  [MAXC];
    logic [63:0] e_rd  [MAXC];
    bit          e_rl  [MAXC];
    bit          e_ov  [MAXC];
    logic [1:0]  e_own [MAXC];

    int         idle_from = 0;
    int         rr = 0;
    logic [1:0] cur_own = 2'd0;

    bit          pend[NREQ];
    bit          hold[NREQ];
    logic [15:0] a_addr[NREQ];
    logic [7:0]  a_len[NREQ];
    bit          rnd_en = 1'b0;

    task automatic clear_from(input int c0);
        for (int c = c0; c < c0 + 300 && c < MAXC; c++) begin
            e_gnt[c] = '0; e_busy[c] = 1'b0; e_addr[c] = '0; e_rv[c] = '0;
            e_rd[c] = '0;  e_rl[c] = 1'b0;   e_ov[c] = 1'b0;  e_own[c] = '0;
        end
    endtask

    // grant decided from the request vector seen in cycle n
    task automatic model_grant(input int n);
        int win;
        int len;
        logic [15:0] base;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && req[(rr + k) % NREQ]) win = (rr + k) % NREQ;
        end
        base = req_addr[win*AW +: AW];
        len  = int'(req_len[win*LW +: LW]);
        e_gnt[n+1] = 3'(1 << win);
        e_ov[n+1]  = 1'b1;
        e_own[n+1] = 2'(win);
        for (int b = 0; b <= len; b++) begin
            logic [15:0] a;
            a = 16'((int'(base) + b) % 65536);
            e_busy[n+1+b] = 1'b1;
            e_addr[n+1+b] = a;
            e_rv[n+2+b]   = 3'(1 << win);
            e_rd[n+2+b]   = memf(a);
            e_rl[n+2+b]   = (b == len);
        end
        idle_from = n + len + 2;
        rr = (win + 1) % NREQ;
    endtask

    task automatic step();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = pend[i];
            req_addr[i*AW +: AW] = a_addr[i];
            req_len[i*LW +: LW]  = a_len[i];
        end
        if (cyc + 300 >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 300);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst) begin
            clear_from(cyc + 1);
            e_ov[cyc+1] = 1'b1;
            e_own[cyc+1] = 2'd0;
            idle_from = cyc + 1;
            rr = 0;
        end else if (cyc >= idle_from && req != '0) begin
            model_grant(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (e_ov[cyc]) cur_own = e_own[cyc];
        check("gnt",    64'(gnt),    64'(e_gnt[cyc]));
        check("busy",   64'(busy),   64'(e_busy[cyc]));
        check("ren",    64'(ren),    64'(e_busy[cyc]));
        if (e_busy[cyc]) check("raddr", 64'(raddr), 64'(e_addr[cyc]));
        check("rvalid", 64'(rvalid), 64'(e_rv[cyc]));
        check("rdata",  rdata,       e_rd[cyc]);
        check("rlast",  64'(rlast),  64'(e_rl[cyc]));
        check("owner",  64'(owner),  64'(cur_own));
        for (int i = 0; i < NREQ; i++) begin
            if (e_gnt[cyc][i] && !hold[i]) pend[i] = 1'b0;
            if (rnd_en && !pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i]   = 1'b1;
                a_addr[i] = 16'($urandom);
                a_len[i]  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40))
                                                         : 8'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic post(input int i, input logic [15:0] a, input logic [7:0] l);
        pend[i] = 1'b1; a_addr[i] = a; a_len[i] = l;
    endtask

    task automatic run_idle(input int max);
        int n;
        bit any;
        n = 0;
        any = 1'b1;
        while (any && n < max) begin
            any = (cyc <= idle_from);
            for (int i = 0; i < NREQ; i++) any |= pend[i];
            if (any) begin
                step();
                n++;
            end
        end
        check("idle_bound", 64'(any), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_addr = '0; req_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; hold[i] = 1'b0; a_addr[i] = '0; a_len[i] = '0;
        end
        clear_from(0);
        for (int c = 300; c < MAXC; c++) begin
            e_gnt[c] = '0; e_busy[c] = 1'b0; e_addr[c] = '0; e_rv[c] = '0;
            e_rd[c] = '0;  e_rl[c] = 1'b0;   e_ov[c] = 1'b0;  e_own[c] = '0;
        end

        // reset with all requesting, then simultaneous single-beat requests
        post(0, 16'h0100, 8'd0);
        post(1, 16'h0200, 8'd0);
        post(2, 16'h0300, 8'd0);
        repeat (3) step();
        rst = 1'b0;
        run_idle(60);

        // single burst
        post(0, 16'h0010, 8'd3);
        run_idle(60);

        // address wrap
        post(1, 16'hFFFE, 8'd3);
        run_idle(60);

        // fairness between two held requesters
        post(0, 16'h1000, 8'd1);
        post(2, 16'h2000, 8'd1);
        hold[0] = 1'b1; hold[2] = 1'b1;
        repeat (20) step();
        hold[0] = 1'b0; hold[2] = 1'b0;
        pend[0] = 1'b0; pend[2] = 1'b0;
        run_idle(60);

        // reset in the middle of a burst, then a fresh request
        post(2, 16'h4000, 8'd7);
        begin
            int n;
            n = 0;
            while (!(e_busy[cyc] && e_addr[cyc] == 16'h4002) && n < 40) begin
                step();
                n++;
            end
            check("mid_burst_reach", 64'(n >= 40), 64'(0));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        pend[2] = 1'b0;
        step();
        post(2, 16'h4000, 8'd7);
        run_idle(60);

        // maximum length burst, wrapping the address space
        post(1, 16'hFF80, 8'd255);
        run_idle(400);

        // random traffic with occasional reset pulses
        rnd_en = 1'b1;
        for (int t = 0; t < 2500; t++) begin
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        rnd_en = 1'b0;
        run_idle(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
